pmem_arbiter: RTL
=================

Name: pmem_arbiter

Overview:
- Shares one physical-memory line port (256-bit read/write, 32-bit address) between the instruction cache (read-only) and the data cache (read/write).
- Sits between the two cache instances and the memory / L2 interface.
- Serialises line transactions with a round-robin tie-break, and returns each response only to the requester that was granted.

Parameters:
- s_line, 256, line width in bits for all data buses.
- s_addr, 32, address width in bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low (asserted when 0).
- i_pmem_read  in  1  icache line-read request; held until i_pmem_resp.
- i_pmem_address  in  s_addr  icache line address.
- i_pmem_rdata  out  s_line  line data to icache.
- i_pmem_resp  out  1  one-cycle done pulse to icache.
- d_pmem_read  in  1  dcache line-read request; held until d_pmem_resp.
- d_pmem_write  in  1  dcache line-writeback request; held until d_pmem_resp.
- d_pmem_address  in  s_addr  dcache line address.
- d_pmem_wdata  in  s_line  dcache writeback data.
- d_pmem_rdata  out  s_line  line data to dcache.
- d_pmem_resp  out  1  one-cycle done pulse to dcache.
- pmem_read  out  1  downstream read strobe, held until pmem_resp.
- pmem_write  out  1  downstream write strobe, held until pmem_resp.
- pmem_address  out  s_addr  downstream address, registered at grant.
- pmem_wdata  out  s_line  downstream write data, registered at grant.
- pmem_rdata  in  s_line  downstream read data, valid with pmem_resp.
- pmem_resp  in  1  downstream one-cycle completion pulse.

Behaviour:
- States: IDLE, BUSY_I, BUSY_D, RELEASE.
- Reset (rst=0, asynchronous):
  - state=IDLE, last_grant=I.
  - pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0.
  - i_pmem_resp=0, d_pmem_resp=0.
- IDLE, grant decision:
  - Only icache requesting -> grant I.
  - Only dcache requesting -> grant D.
  - Both requesting -> grant the side not equal to last_grant. The first tie after reset therefore goes to D.
  - None requesting -> stay in IDLE.
- On grant, at the next edge:
  - Latch pmem_address, and pmem_wdata (D only).
  - Assert pmem_read or pmem_write.
  - Update last_grant; enter BUSY_I or BUSY_D.
  - Latency: request seen at edge N -> pmem strobe high after edge N (one cycle).
- Dcache with read and write both high (illegal) -> treat as write.
- BUSY_x:
  - Strobes, address and wdata are held stable until pmem_resp.
  - In the pmem_resp cycle, x_pmem_resp = 1 combinationally. All other cycles it is 0.
  - At that edge: drop strobes, enter RELEASE.
  - x_pmem_rdata = pmem_rdata (passthrough; valid only when x_pmem_resp=1).
  - The non-granted resp output is always 0.
- RELEASE:
  - One idle cycle, strobes low, no grant evaluated. This lets the requester drop its request so it is not re-served.
  - Then go to IDLE.
  - Back-to-back turnaround: 2 cycles from pmem_resp to the next strobe.
- Requester drops its request mid-transaction:
  - The downstream transaction still completes.
  - The resp is still pulsed; the cache ignores it.
  - No abort is possible.
- pmem_resp arriving in IDLE or RELEASE -> ignored; no resp output.
- Reset asserted mid-transaction -> all outputs to 0 immediately and state=IDLE. The downstream side is reset by the same rst.
- Requests arriving while BUSY are held off, not queued; they are served after RELEASE.

Decomposition:
- Shared package pmem_arb_types:
  - arb_state_t enum {IDLE, BUSY_I, BUSY_D, RELEASE}.
  - grant_t enum {GRANT_I, GRANT_D}.
- No sub-module. FSM plus registered-output logic live in one module, using one always_ff and one always_comb for next state and grant.

Test Plan:
- Reset: hold rst=0 with i/d requests high -> all pmem strobes and resps 0; after release, first IDLE edge grants per rules.
- Icache alone: i read to 0x0000_1000, pmem_resp three cycles after strobe with rdata=0xA5..A5 -> i_pmem_resp one pulse, i_pmem_rdata matches, d_pmem_resp stays 0.
- Dcache writeback: address 0x0000_2020, wdata=0xDEAD..BEEF -> pmem_write high, address and wdata stable until pmem_resp, then RELEASE; pmem_read never asserted.
- Simultaneous requests from reset: D served first; I served next, strobe 2 cycles after D's resp; then both again -> D wins (last_grant=I).
- Dcache read and write both high -> pmem_write only; a stray pmem_resp while IDLE -> no resp output.
- Reset mid-BUSY_D: pmem_write falls asynchronously; after release, the held dcache request is re-granted cleanly.

Source files
------------

// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the physical-memory line-port arbiter.
package pmem_arb_types;

   // Arbiter FSM states.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_I  = 2'd1,
      BUSY_D  = 2'd2,
      RELEASE = 2'd3
   } arb_state_t;

   // Which cache owns (or last owned) the downstream port.
   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } grant_t;

endpackage

// File: rtl/pmem_arbiter.sv
// Shares one 256-bit physical-memory line port between the icache (read-only)
// and the dcache (read/write). One transaction at a time, round-robin on ties,
// response routed only to the granted cache. A one-cycle RELEASE gap after
// every completion gives the served cache time to drop its request.
module pmem_arbiter
   import pmem_arb_types::*;
#(
   parameter int s_line = 256,
   parameter int s_addr = 32
)
(
   input  logic              clk,
   input  logic              rst,

   input  logic              i_pmem_read,
   input  logic [s_addr-1:0] i_pmem_address,
   output logic [s_line-1:0] i_pmem_rdata,
   output logic              i_pmem_resp,

   input  logic              d_pmem_read,
   input  logic              d_pmem_write,
   input  logic [s_addr-1:0] d_pmem_address,
   input  logic [s_line-1:0] d_pmem_wdata,
   output logic [s_line-1:0] d_pmem_rdata,
   output logic              d_pmem_resp,

   output logic              pmem_read,
   output logic              pmem_write,
   output logic [s_addr-1:0] pmem_address,
   output logic [s_line-1:0] pmem_wdata,
   input  logic [s_line-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   arb_state_t state_r;
   arb_state_t state_next_s;
   grant_t     last_grant_r;
   grant_t     grant_s;
   logic       grant_valid_s;
   logic       i_req_s;
   logic       d_req_s;

   assign i_req_s = i_pmem_read;
   assign d_req_s = d_pmem_read | d_pmem_write;

   // Responses are only ever steered to the cache that owns the port.
   assign i_pmem_resp  = (state_r == BUSY_I) & pmem_resp;
   assign d_pmem_resp  = (state_r == BUSY_D) & pmem_resp;
   assign i_pmem_rdata = pmem_rdata;
   assign d_pmem_rdata = pmem_rdata;

   // Next-state and grant decision; grants are only evaluated in IDLE.
   always_comb begin
      state_next_s  = state_r;
      grant_valid_s = 1'b0;
      grant_s       = last_grant_r;
      case (state_r)
         IDLE: begin
            if (i_req_s && d_req_s) begin
               grant_valid_s = 1'b1;
               grant_s       = (last_grant_r == GRANT_I) ? GRANT_D : GRANT_I;
            end else if (d_req_s) begin
               grant_valid_s = 1'b1;
               grant_s       = GRANT_D;
            end else if (i_req_s) begin
               grant_valid_s = 1'b1;
               grant_s       = GRANT_I;
            end else begin
               grant_valid_s = 1'b0;
            end
            if (grant_valid_s) begin
               state_next_s = (grant_s == GRANT_D) ? BUSY_D : BUSY_I;
            end else begin
               state_next_s = IDLE;
            end
         end
         BUSY_I, BUSY_D: begin
            if (pmem_resp) begin
               state_next_s = RELEASE;
            end else begin
               state_next_s = state_r;
            end
         end
         RELEASE: begin
            state_next_s = IDLE;
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // State, round-robin history and registered downstream request fields.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= IDLE;
         last_grant_r <= GRANT_I;
         pmem_read    <= 1'b0;
         pmem_write   <= 1'b0;
         pmem_address <= {s_addr{1'b0}};
         pmem_wdata   <= {s_line{1'b0}};
      end else begin
         state_r <= state_next_s;
         if (grant_valid_s) begin
            last_grant_r <= grant_s;
            if (grant_s == GRANT_D) begin
               // Read and write together is illegal; the write takes priority.
               pmem_address <= d_pmem_address;
               pmem_wdata   <= d_pmem_wdata;
               pmem_write   <= d_pmem_write;
               pmem_read    <= ~d_pmem_write;
            end else begin
               pmem_address <= i_pmem_address;
               pmem_read    <= 1'b1;
               pmem_write   <= 1'b0;
            end
         end else if (state_next_s == RELEASE) begin
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
         end else begin
            pmem_read  <= pmem_read;
            pmem_write <= pmem_write;
         end
      end
   end

endmodule
